// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the soft-CPU run/step controller: FSM state
// encoding and the default debounce length.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    READY     = 3'd1,
    RUN       = 3'd2,
    STEP_IDLE = 3'd3,
    STEP_EXEC = 3'd4,
    HALT      = 3'd5
  } state_e;

  // 10 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-time debouncer; emits the
// debounced level and a one-cycle registered pulse on its 0->1 change.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_comb begin
    sync_d  = {sync_q[0], i_raw};
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    // Counter only runs while the synchronized input disagrees with the level
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: gates the soft-CPU clock enable for free-run or
// one-instruction-per-press execution and latches halt until reset.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_start,
  input  logic i_btn_step,
  input  logic i_sw_step_mode,
  input  logic i_instr_transmit_done,
  input  logic i_cpu_instr_done,
  input  logic i_cpu_halt,
  output logic o_cpu_en,
  output logic o_instr_loaded,
  output logic o_start_cpu,
  output logic o_halt,
  output logic o_step_execution
);

  logic   start_lvl, start_press;
  logic   step_lvl, step_press;
  logic   mode_lvl, mode_rise;
  state_e state_q, state_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_start (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_btn_start),
    .o_level(start_lvl), .o_rise(start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_step (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_btn_step),
    .o_level(step_lvl), .o_rise(step_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_mode (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_sw_step_mode),
    .o_level(mode_lvl), .o_rise(mode_rise)
  );

  // Buttons act on press edges and the switch on its level; the rest is spare
  logic unused_dbnc;
  assign unused_dbnc = ^{start_lvl, step_lvl, mode_rise};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:      if (i_instr_transmit_done) state_d = READY;
      READY:     if (start_press) state_d = mode_lvl ? STEP_IDLE : RUN;
      RUN: begin
        if (i_cpu_halt)                        state_d = HALT;
        else if (mode_lvl && i_cpu_instr_done) state_d = STEP_IDLE;
      end
      STEP_IDLE: begin
        if (i_cpu_halt)      state_d = HALT;
        else if (!mode_lvl)  state_d = RUN;
        else if (step_press) state_d = STEP_EXEC;
      end
      STEP_EXEC: begin
        if (i_cpu_halt)            state_d = HALT;
        else if (i_cpu_instr_done) state_d = STEP_IDLE;
      end
      HALT:      state_d = HALT;
      default:   state_d = LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= LOAD;
    else          state_q <= state_d;
  end

  // Outputs decode only the state register and the debounced mode flop
  assign o_cpu_en         = (state_q == RUN) || (state_q == STEP_EXEC);
  assign o_instr_loaded   = (state_q != LOAD);
  assign o_start_cpu      = (state_q == RUN) || (state_q == STEP_IDLE) ||
                            (state_q == STEP_EXEC) || (state_q == HALT);
  assign o_halt           = (state_q == HALT);
  assign o_step_execution = mode_lvl;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a 4-cycle debounce: bounce rejection,
// free-run, single step, mode switch, halt priority and reset behaviour.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_start, btn_step, sw_mode, xfer_done, instr_done, cpu_halt;
  logic cpu_en, instr_loaded, start_cpu, halt, step_exec;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  int en_base;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_btn_start(btn_start), .i_btn_step(btn_step), .i_sw_step_mode(sw_mode),
    .i_instr_transmit_done(xfer_done), .i_cpu_instr_done(instr_done),
    .i_cpu_halt(cpu_halt),
    .o_cpu_en(cpu_en), .o_instr_loaded(instr_loaded), .o_start_cpu(start_cpu),
    .o_halt(halt), .o_step_execution(step_exec)
  );

  always @(negedge clk) if (cpu_en) en_cnt <= en_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    repeat (7) tick();
    btn_start = 1'b0;
    repeat (6) tick();
  endtask

  task automatic load_pulse();
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; btn_start = 1'b0; btn_step = 1'b0; sw_mode = 1'b0;
    xfer_done = 1'b0; instr_done = 1'b0; cpu_halt = 1'b0;
    tick(); tick();
    chk("rst_en", cpu_en, 1'b0);
    chk("rst_loaded", instr_loaded, 1'b0);
    chk("rst_start", start_cpu, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_stepexec", step_exec, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("load_loaded", instr_loaded, 1'b0);

    load_pulse();
    chk("ready_loaded", instr_loaded, 1'b1);
    chk("ready_start", start_cpu, 1'b0);
    chk("ready_en", cpu_en, 1'b0);

    // Bouncing start: 2 cycles high / 2 low, never stable for 4 cycles
    en_base = en_cnt;
    for (int i = 0; i < 5; i++) begin
      btn_start = 1'b1; tick(); tick();
      btn_start = 1'b0; tick(); tick();
    end
    btn_start = 1'b1;
    repeat (6) tick();
    chk("bounce_no_run_yet", cpu_en, 1'b0);
    chk("bounce_en_cycles", en_cnt - en_base, 0);
    tick();
    chk("bounce_run_en", cpu_en, 1'b1);
    chk("run_start_cpu", start_cpu, 1'b1);
    chk("run_loaded", instr_loaded, 1'b1);
    btn_start = 1'b0;

    en_base = en_cnt;
    repeat (10) tick();
    chk("freerun_en_cycles", en_cnt - en_base, 10);
    chk("freerun_en", cpu_en, 1'b1);

    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    chk("halt_en", cpu_en, 1'b0);
    chk("halt_flag", halt, 1'b1);
    btn_start = 1'b1; btn_step = 1'b1;
    repeat (8) tick();
    btn_start = 1'b0; btn_step = 1'b0;
    repeat (8) tick();
    chk("halt_sticky_en", cpu_en, 1'b0);
    chk("halt_sticky_flag", halt, 1'b1);
    chk("halt_start_cpu", start_cpu, 1'b1);

    rst_n = 1'b0;
    #1;
    chk("rst_from_halt", halt, 1'b0);
    rst_n = 1'b1;
    tick();
    load_pulse();
    press_start();
    chk("rerun_en", cpu_en, 1'b1);

    // Mode raised mid-run; takes effect only on instruction done
    sw_mode = 1'b1;
    repeat (6) tick();
    chk("mode_level", step_exec, 1'b1);
    chk("mode_still_run", cpu_en, 1'b1);
    repeat (4) tick();
    chk("mode_pre_done_en", cpu_en, 1'b1);
    instr_done = 1'b1;
    chk("mode_done_cycle_en", cpu_en, 1'b1);
    tick();
    instr_done = 1'b0;
    chk("mode_stop_en", cpu_en, 1'b0);
    chk("mode_stepexec", step_exec, 1'b1);

    // Single step, 3-cycle instruction
    en_base = en_cnt;
    btn_step = 1'b1;
    repeat (6) tick();
    chk("step_pre_en", cpu_en, 1'b0);
    tick();
    chk("step_e1", cpu_en, 1'b1);
    tick();
    chk("step_e2", cpu_en, 1'b1);
    tick();
    chk("step_e3", cpu_en, 1'b1);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    chk("step_after_en", cpu_en, 1'b0);
    chk("step_en_cycles", en_cnt - en_base, 3);
    btn_step = 1'b0;
    repeat (6) tick();
    chk("step_idle_en", cpu_en, 1'b0);

    // Second press lands while STEP_EXEC is still busy
    btn_step = 1'b1;
    repeat (7) tick();
    chk("step2_exec_en", cpu_en, 1'b1);
    btn_step = 1'b0;
    repeat (6) tick();
    btn_step = 1'b1;
    repeat (7) tick();
    chk("step2_still_exec", cpu_en, 1'b1);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    en_base = en_cnt;
    chk("step2_done_en", cpu_en, 1'b0);
    repeat (8) tick();
    chk("step2_not_queued", en_cnt - en_base, 0);
    btn_step = 1'b0;
    repeat (6) tick();

    // Halt and instruction done together in STEP_EXEC
    btn_step = 1'b1;
    repeat (7) tick();
    chk("simul_exec_en", cpu_en, 1'b1);
    cpu_halt = 1'b1; instr_done = 1'b1;
    tick();
    cpu_halt = 1'b0; instr_done = 1'b0; btn_step = 1'b0;
    chk("simul_halt", halt, 1'b1);
    chk("simul_en", cpu_en, 1'b0);

    // Asynchronous reset in the middle of RUN
    sw_mode = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    load_pulse();
    press_start();
    chk("rst2_run_en", cpu_en, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_en", cpu_en, 1'b0);
    chk("async_loaded", instr_loaded, 1'b0);
    chk("async_start", start_cpu, 1'b0);
    chk("async_halt", halt, 1'b0);
    chk("async_stepexec", step_exec, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    btn_start = 1'b1;
    repeat (8) tick();
    chk("noload_en", cpu_en, 1'b0);
    chk("noload_start", start_cpu, 1'b0);
    chk("noload_loaded", instr_loaded, 1'b0);
    btn_start = 1'b0;
    repeat (6) tick();
    load_pulse();
    chk("reload_loaded", instr_loaded, 1'b1);
    chk("reload_start", start_cpu, 1'b0);
    repeat (3) tick();
    chk("reload_en", cpu_en, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
